// File: rtl/string_mem_loader.sv
// rtl/string_mem_loader.sv - byte-stream loader that fills CPU data memory with text and pattern operands
//
// Ports:
//   reset, clk                  asynchronous active-high reset, rising-edge clock
//   start                       one-cycle pulse, begins loading (IDLE only)
//   byte_valid/byte_data/
//   byte_last/byte_ready        byte-stream handshake; byte_last closes a segment
//   mem_wr_en/addr/data         registered word write into CPU data memory
//   str_len, pat_len            live text / pattern character counters
//   overflow                    sticky, a segment ran past its maximum length
//   cpu_reset, done             CPU held in reset until loading has completed

module string_mem_loader #(
    parameter logic [31:0] STR_BASE = 32'h00000000,
    parameter logic [31:0] PAT_BASE = 32'h00000400,
    parameter int          MAX_STR  = 256,
    parameter int          MAX_PAT  = 256,
    parameter int          LEN_W    = 9
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic             mem_wr_en,
    output logic [31:0]      mem_wr_addr,
    output logic [31:0]      mem_wr_data,
    output logic [LEN_W-1:0] str_len,
    output logic [LEN_W-1:0] pat_len,
    output logic             overflow,
    output logic             cpu_reset,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        FLUSH,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] STR_LIMIT = LEN_W'(MAX_STR);
    localparam logic [LEN_W-1:0] PAT_LIMIT = LEN_W'(MAX_PAT);

    state_t state;
    logic   accept;

    // Ready is a pure decode of the registered state: the loader never back-pressures
    // while a segment is open and never accepts outside one.
    assign byte_ready = (state == LOAD_STR) || (state == LOAD_PAT);
    assign accept     = byte_valid & byte_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 32'h0;
            mem_wr_data <= 32'h0;
            str_len     <= '0;
            pat_len     <= '0;
            overflow    <= 1'b0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
        end else begin
            // Write strobe is a one-cycle pulse following each stored byte.
            mem_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_STR;
                    end
                end

                LOAD_STR: begin
                    if (accept) begin
                        if (str_len < STR_LIMIT) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= STR_BASE + (32'(str_len) << 2);
                            mem_wr_data <= {24'b0, byte_data};
                            str_len     <= str_len + 1'b1;
                        end else begin
                            // Counter saturates; excess bytes are dropped.
                            overflow <= 1'b1;
                        end
                        if (byte_last) begin
                            state <= LOAD_PAT;
                        end
                    end
                end

                LOAD_PAT: begin
                    if (accept) begin
                        if (pat_len < PAT_LIMIT) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= PAT_BASE + (32'(pat_len) << 2);
                            mem_wr_data <= {24'b0, byte_data};
                            pat_len     <= pat_len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (byte_last) begin
                            state <= FLUSH;
                        end
                    end
                end

                // The final pattern write is on the bus during this cycle, so the
                // CPU is released only once it has landed.
                FLUSH: begin
                    state     <= DONE;
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_string_mem_loader.sv
// tb/tb_string_mem_loader.sv - directed table-driven bench for string_mem_loader

module tb_string_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;

    logic        a_ready, a_wr_en, a_overflow, a_cpu_reset, a_done;
    logic [31:0] a_addr, a_data;
    logic [8:0]  a_str_len, a_pat_len;

    logic        b_ready, b_wr_en, b_overflow, b_cpu_reset, b_done;
    logic [31:0] b_addr, b_data;
    logic [8:0]  b_str_len, b_pat_len;

    always #5 clk = ~clk;

    string_mem_loader dut_a (
        .reset(reset), .clk(clk), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(a_ready), .mem_wr_en(a_wr_en), .mem_wr_addr(a_addr), .mem_wr_data(a_data),
        .str_len(a_str_len), .pat_len(a_pat_len), .overflow(a_overflow),
        .cpu_reset(a_cpu_reset), .done(a_done)
    );

    string_mem_loader #(.MAX_STR(4)) dut_b (
        .reset(reset), .clk(clk), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(b_ready), .mem_wr_en(b_wr_en), .mem_wr_addr(b_addr), .mem_wr_data(b_data),
        .str_len(b_str_len), .pat_len(b_pat_len), .overflow(b_overflow),
        .cpu_reset(b_cpu_reset), .done(b_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory image of every write seen on each DUT.
    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] mem_b [logic [31:0]];
    int wr_a = 0;
    int wr_b = 0;

    always @(negedge clk) begin
        if (a_wr_en) begin
            mem_a[a_addr] = a_data;
            wr_a++;
        end
        if (b_wr_en) begin
            mem_b[b_addr] = b_data;
            wr_b++;
        end
    end

    typedef struct {
        bit          valid;
        bit [7:0]    data;
        bit          last;
        bit          exp_wen;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit v, input bit [7:0] d, input bit l, input bit w, input logic [31:0] a);
        vec_t r;
        r.valid = v; r.data = d; r.last = l; r.exp_wen = w; r.exp_addr = a;
        vecs.push_back(r);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input bit [7:0] d, input bit l);
        byte_valid = 1'b1; byte_data = d; byte_last = l;
        tick;
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    // Each record is driven for one cycle; the write it causes is visible right after that edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            byte_valid = vecs[i].valid;
            byte_data  = vecs[i].data;
            byte_last  = vecs[i].last;
            tick;
            chk($sformatf("%s[%0d] wr_en", tag, i), 32'(a_wr_en), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_wen) begin
                chk($sformatf("%s[%0d] addr", tag, i), a_addr, vecs[i].exp_addr);
                chk($sformatf("%s[%0d] data", tag, i), a_data, {24'b0, vecs[i].data});
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    string txt = "abaaababbabababaabababbab";
    string pat = "ababa";
    int w0;
    int bad;
    int gaps;

    initial begin
        // Reset state and quiet idle
        tick; tick;
        chk("rst cpu_reset", 32'(a_cpu_reset), 32'd1);
        chk("rst wr_en", 32'(a_wr_en), 32'd0);
        chk("rst done", 32'(a_done), 32'd0);
        chk("rst byte_ready", 32'(a_ready), 32'd0);
        chk("rst str_len", 32'(a_str_len), 32'd0);
        chk("rst overflow", 32'(a_overflow), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (a_wr_en || !a_cpu_reset || a_ready) bad++;
        end
        chk("idle bad cycles", 32'(bad), 32'd0);

        // Full back-to-back load
        vecs.delete();
        for (int i = 0; i < 25; i++) add_vec(1, txt[i], i == 24, 1, 32'h0 + 32'(4 * i));
        for (int i = 0; i < 5; i++) add_vec(1, pat[i], i == 4, 1, 32'h400 + 32'(4 * i));
        pulse_start;
        w0 = wr_a;
        run_vecs("full");
        chk("flush cpu_reset", 32'(a_cpu_reset), 32'd1);
        chk("flush done", 32'(a_done), 32'd0);
        tick;
        chk("full cpu_reset", 32'(a_cpu_reset), 32'd0);
        chk("full done", 32'(a_done), 32'd1);
        chk("full str_len", 32'(a_str_len), 32'd25);
        chk("full pat_len", 32'(a_pat_len), 32'd5);
        chk("full writes", 32'(wr_a - w0), 32'd30);
        chk("full mem 408", mem_a[32'h408], 32'h00000061);
        chk("full mem 060", mem_a[32'h060], 32'h00000062);
        chk("full overflow", 32'(a_overflow), 32'd0);

        // DONE ignores start and bytes
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
        tick;
        start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        chk("lock byte_ready", 32'(a_ready), 32'd0);
        chk("lock wr_en", 32'(a_wr_en), 32'd0);
        tick;
        chk("lock done", 32'(a_done), 32'd1);
        chk("lock cpu_reset", 32'(a_cpu_reset), 32'd0);
        chk("lock wr_en2", 32'(a_wr_en), 32'd0);
        chk("lock str_len", 32'(a_str_len), 32'd25);

        // Gapped valid: "ab" then "a", idle cycles carry junk that must be ignored
        do_reset;
        vecs.delete();
        gaps = $urandom_range(1, 3);
        for (int g = 0; g < gaps; g++) add_vec(0, 8'hee, 1, 0, 32'h0);
        add_vec(1, 8'h61, 0, 1, 32'h000);
        gaps = $urandom_range(1, 3);
        for (int g = 0; g < gaps; g++) add_vec(0, 8'hee, 1, 0, 32'h0);
        add_vec(1, 8'h62, 1, 1, 32'h004);
        gaps = $urandom_range(1, 3);
        for (int g = 0; g < gaps; g++) add_vec(0, 8'hee, 1, 0, 32'h0);
        add_vec(1, 8'h61, 1, 1, 32'h400);
        pulse_start;
        run_vecs("gap");
        tick;
        chk("gap done", 32'(a_done), 32'd1);
        chk("gap str_len", 32'(a_str_len), 32'd2);
        chk("gap pat_len", 32'(a_pat_len), 32'd1);

        // Overflow on the MAX_STR=4 instance
        do_reset;
        pulse_start;
        w0 = wr_b;
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), i == 5);
        send(8'h70, 1);
        tick;
        chk("ovf writes", 32'(wr_b - w0), 32'd5);
        chk("ovf str_len", 32'(b_str_len), 32'd4);
        chk("ovf pat_len", 32'(b_pat_len), 32'd1);
        chk("ovf flag", 32'(b_overflow), 32'd1);
        chk("ovf mem 400", mem_b[32'h400], 32'h00000070);
        chk("ovf mem 00c", mem_b[32'h00c], 32'h00000033);
        chk("ovf no 010", 32'(mem_b.exists(32'h010)), 32'd0);
        chk("ovf done", 32'(b_done), 32'd1);
        chk("ovf wide clean", 32'(a_overflow), 32'd0);

        // Asynchronous reset mid-load
        do_reset;
        pulse_start;
        send(8'h41, 0); send(8'h42, 0); send(8'h43, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst cpu_reset", 32'(a_cpu_reset), 32'd1);
        chk("midrst str_len", 32'(a_str_len), 32'd0);
        chk("midrst wr_en", 32'(a_wr_en), 32'd0);
        chk("midrst byte_ready", 32'(a_ready), 32'd0);
        tick;
        reset = 1'b0;
        pulse_start;
        send(8'h44, 0);
        chk("reload wr_en", 32'(a_wr_en), 32'd1);
        chk("reload addr", a_addr, 32'h000);
        chk("reload data", a_data, 32'h00000044);

        // start together with byte_valid in IDLE
        do_reset;
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h7a; byte_last = 1'b1;
        tick;
        start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        chk("coll wr_en", 32'(a_wr_en), 32'd0);
        chk("coll byte_ready", 32'(a_ready), 32'd1);
        chk("coll str_len", 32'(a_str_len), 32'd0);
        send(8'h62, 1);
        chk("coll first addr", a_addr, 32'h000);
        chk("coll first data", a_data, 32'h00000062);
        send(8'h61, 1);
        chk("coll pat addr", a_addr, 32'h400);
        tick;
        chk("coll done", 32'(a_done), 32'd1);
        chk("coll str_len final", 32'(a_str_len), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
